// File: rtl/decoder.sv
// Registered 10b->8b line decoder: two independent 5-bit symbols decode to one nibble each.
// Also reports the popcount of each half and flags illegal symbols.
module decoder (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic [9:0] data_i,
  output logic [7:0] out8b_o,
  output logic [2:0] pop_h,
  output logic [2:0] pop_l,
  output logic       valid_o,
  output logic       code_err_o
);

  // Returns {illegal, nibble}; every weight-2/3 symbol has a mapping.
  function automatic logic [4:0] dec_sym(input logic [4:0] c);
    logic [4:0] r;
    case (c)
      5'b00011: r = 5'b0_0011;
      5'b00101: r = 5'b0_0101;
      5'b00110: r = 5'b0_0110;
      5'b01001: r = 5'b0_1001;
      5'b01010: r = 5'b0_1010;
      5'b01100: r = 5'b0_1100;
      5'b00111: r = 5'b0_0111;
      5'b01011: r = 5'b0_1011;
      5'b01101: r = 5'b0_1101;
      5'b01110: r = 5'b0_1110;
      5'b10001: r = 5'b0_0001;
      5'b10010: r = 5'b0_0010;
      5'b10100: r = 5'b0_0100;
      5'b11000: r = 5'b0_1000;
      5'b11100: r = 5'b0_1111;
      5'b10011: r = 5'b0_0000;
      5'b10101: r = 5'b0_1010;
      5'b10110: r = 5'b0_1001;
      5'b11001: r = 5'b0_0110;
      5'b11010: r = 5'b0_0101;
      default:  r = 5'b1_0000;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] pop5(input logic [4:0] c);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, c[i]};
    end
    return n;
  endfunction

  logic [4:0] dec_h;
  logic [4:0] dec_l;

  always_comb begin
    dec_h = dec_sym(data_i[9:5]);
    dec_l = dec_sym(data_i[4:0]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out8b_o    <= 8'h00;
      pop_h      <= 3'd0;
      pop_l      <= 3'd0;
      valid_o    <= 1'b0;
      code_err_o <= 1'b0;
    end else if (enable_i) begin
      out8b_o    <= {dec_h[3:0], dec_l[3:0]};
      pop_h      <= pop5(data_i[9:5]);
      pop_l      <= pop5(data_i[4:0]);
      valid_o    <= 1'b1;
      code_err_o <= dec_h[4] | dec_l[4];
    end else begin
      valid_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_decoder;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       enable_i = 1'b0;
  logic [9:0] data_i = 10'd0;
  logic [7:0] out8b_o;
  logic [2:0] pop_h;
  logic [2:0] pop_l;
  logic       valid_o;
  logic       code_err_o;

  typedef struct packed {
    logic [7:0] o;
    logic [2:0] ph;
    logic [2:0] pl;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;
  logic [3:0] alias_map[logic [4:0]];
  int n_checks = 0;
  int n_fail = 0;

  decoder dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .data_i(data_i),
    .out8b_o(out8b_o), .pop_h(pop_h), .pop_l(pop_l),
    .valid_o(valid_o), .code_err_o(code_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: legality by weight, plain nibble for c[4]=0, otherwise the listed alias table.
  function automatic logic [4:0] ref_sym(input logic [4:0] c);
    int w;
    w = $countones(c);
    if (w < 2 || w > 3) return 5'b1_0000;
    if (!c[4]) return {1'b0, c[3:0]};
    if (alias_map.exists(c)) return {1'b0, alias_map[c]};
    return 5'b1_0000;
  endfunction

  function automatic exp_t model(input logic [9:0] d);
    exp_t e;
    logic [4:0] h, l;
    h = ref_sym(d[9:5]);
    l = ref_sym(d[4:0]);
    e.o   = {h[3:0], l[3:0]};
    e.ph  = 3'($countones(d[9:5]));
    e.pl  = 3'($countones(d[4:0]));
    e.err = h[4] | l[4];
    return e;
  endfunction

  task automatic drive(input logic en, input logic [9:0] d, input logic use_exp, input exp_t e);
    @(posedge clk_i);
    #1;
    enable_i = en;
    data_i   = d;
    if (en && rst_ni) exp_q.push_back(use_exp ? e : model(d));
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_ni) begin
      held = '0;
      chk("reset_out", out8b_o, 0);
      chk("reset_valid", valid_o, 0);
      chk("reset_err", code_err_o, 0);
      chk("reset_pop", {pop_h, pop_l}, 0);
    end else if (valid_o) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", valid_o, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out8b", out8b_o, e.o);
        chk("pop_h", pop_h, e.ph);
        chk("pop_l", pop_l, e.pl);
        chk("code_err", code_err_o, e.err);
        held = e;
      end
    end else begin
      chk("hold_out", out8b_o, held.o);
      chk("hold_pop", {pop_h, pop_l}, {held.ph, held.pl});
      chk("hold_err", code_err_o, held.err);
    end
  end

  initial begin
    exp_t z;
    z = '0;
    held = '0;
    alias_map[5'b10001] = 4'b0001;
    alias_map[5'b10010] = 4'b0010;
    alias_map[5'b10100] = 4'b0100;
    alias_map[5'b11000] = 4'b1000;
    alias_map[5'b11100] = 4'b1111;
    alias_map[5'b10011] = 4'b0000;
    alias_map[5'b10101] = 4'b1010;
    alias_map[5'b10110] = 4'b1001;
    alias_map[5'b11001] = 4'b0110;
    alias_map[5'b11010] = 4'b0101;

    // Reset held with an enabled legal word on the input.
    enable_i = 1'b1;
    data_i   = 10'b00111_00110;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    rst_ni = 1'b1;
    exp_q.push_back('{o: 8'h76, ph: 3'd3, pl: 3'd2, err: 1'b0});

    drive(1, 10'b11010_01010, 1, '{o: 8'h5A, ph: 3'd3, pl: 3'd2, err: 1'b0});
    drive(1, 10'b11010_10100, 1, '{o: 8'h54, ph: 3'd3, pl: 3'd2, err: 1'b0});
    drive(1, 10'b11100_11000, 1, '{o: 8'hF8, ph: 3'd3, pl: 3'd2, err: 1'b0});
    drive(1, 10'b00110_10011, 1, '{o: 8'h60, ph: 3'd2, pl: 3'd3, err: 1'b0});
    drive(1, 10'b11111_00000, 1, '{o: 8'h00, ph: 3'd5, pl: 3'd0, err: 1'b1});
    drive(1, 10'b00000_10101, 1, '{o: 8'h0A, ph: 3'd0, pl: 3'd3, err: 1'b1});
    for (int i = 0; i < 4; i++) drive(0, 10'($urandom), 0, z);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 10'($urandom), 0, z);
    end

    // Asynchronous reset between edges, after a word has been captured.
    drive(1, 10'b01110_11100, 0, z);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_out", out8b_o, 0);
    chk("async_rst_valid", valid_o, 0);
    chk("async_rst_pop", {pop_h, pop_l}, 0);
    chk("async_rst_err", code_err_o, 0);
    enable_i = 1'b1;
    data_i   = 10'b10110_01001;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    rst_ni = 1'b1;
    exp_q.push_back(model(data_i));
    for (int i = 0; i < 100; i++) begin
      drive(($urandom_range(0, 1) != 0), 10'($urandom), 0, z);
    end
    drive(0, 10'd0, 0, z);
    repeat (3) @(posedge clk_i);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
